// File: rtl/op_sequencer.sv
// Command front-end for the matrix controller: queues {operation, beat count} instructions and
// replays each as IDLE -> RUN -> GAP. Define OP_SEQUENCER_PERF_EN to add stall/instruction counters.
module op_sequencer #(
  parameter int LEN_W      = 16,
  parameter int CMD_DEPTH  = 4,
  parameter int RD_LAT     = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  input  logic [31:0]      wdata,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [31:0]      result_data,
  output logic [31:0]      ctrl_operation,
  output logic [31:0]      ctrl_in_data,
  output logic             ctrl_enable,
  input  logic [31:0]      ctrl_out_data,
  output logic             busy,
  output logic             done
`ifdef OP_SEQUENCER_PERF_EN
  ,
  output logic [31:0]      stall_count,
  output logic [31:0]      instr_count
`endif
);

  localparam int AW = $clog2(CMD_DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = LEN_W + 2;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(CMD_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

  state_t           state;
  logic [31:0]      op_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W:0]   cnt;
  logic [GW-1:0]    gap_cnt;

  logic [31:0]      fifo_op  [CMD_DEPTH];
  logic [LEN_W-1:0] fifo_len [CMD_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, empty, push, pop;

  logic             is_run, is_wr, is_rd, last_beat;
  logic [TW-1:0]    total;

  assign full      = (count == DEPTH_V);
  assign empty     = (count == '0);
  assign cmd_ready = !full && !reset;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == S_IDLE) && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr]  <= cmd_op;
      fifo_len[wr_ptr] <= cmd_len;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Read instructions run RD_LAT extra beats so the last word can drain out of the controller.
  assign is_run    = (state == S_RUN);
  assign is_wr     = is_run && (op_reg[3:0] == 4'd2);
  assign is_rd     = is_run && (op_reg[3:0] == 4'd3);
  assign total     = TW'(len_reg) + ((op_reg[3:0] == 4'd3) ? TW'(RD_LAT) : TW'(0));
  assign last_beat = ((TW'(cnt) + TW'(1)) == total);

  assign result_valid   = is_rd && (cnt >= (LEN_W+1)'(RD_LAT));
  assign result_data    = is_rd ? ctrl_out_data : '0;
  assign wdata_ready    = is_wr;
  assign ctrl_in_data   = is_wr ? wdata : '0;
  assign ctrl_operation = op_reg;
  assign busy           = (state != S_IDLE) || !empty;

  always_comb begin
    ctrl_enable = 1'b1;
    if (is_wr)      ctrl_enable = wdata_valid;
    else if (is_rd) ctrl_enable = !(result_valid && !result_ready);
    if (reset)      ctrl_enable = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      op_reg  <= '0;
      len_reg <= '0;
      cnt     <= '0;
      gap_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!empty) begin
            len_reg <= fifo_len[rd_ptr];
            cnt     <= '0;
            // Zero-length commands are dropped without ever leaving IDLE.
            if (fifo_len[rd_ptr] != '0) begin
              op_reg <= fifo_op[rd_ptr];
              state  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (ctrl_enable) begin
            cnt <= cnt + 1'b1;
            if (last_beat) begin
              state   <= S_GAP;
              op_reg  <= '0;
              done    <= 1'b1;
              gap_cnt <= '0;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= S_IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef OP_SEQUENCER_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      instr_count <= '0;
    end else begin
      if (is_run && !ctrl_enable && (stall_count != '1)) stall_count <= stall_count + 1'b1;
      if (done && (instr_count != '1)) instr_count <= instr_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: stimulus tasks push expected instruction records, write words
// and read words into queues; a negedge monitor pops and compares as the DUT presents them.
module tb_op_sequencer;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [31:0]      cmd_op = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             wdata_valid = 1'b0;
  logic             wdata_ready;
  logic [31:0]      wdata = '0;
  logic             result_valid;
  logic             result_ready = 1'b1;
  logic [31:0]      result_data;
  logic [31:0]      ctrl_operation;
  logic [31:0]      ctrl_in_data;
  logic             ctrl_enable;
  logic [31:0]      ctrl_out_data = '0;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  op_sequencer #(.LEN_W(LEN_W), .CMD_DEPTH(4), .RD_LAT(1), .GAP_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
    .ctrl_operation(ctrl_operation), .ctrl_in_data(ctrl_in_data), .ctrl_enable(ctrl_enable),
    .ctrl_out_data(ctrl_out_data), .busy(busy), .done(done)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_cond(input string name, input bit ok, input logic [63:0] act);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: condition false, observed %0d", name, act);
    end
  endtask

  // Controller stand-in: each enabled opcode-3 beat fetches the next word (RD_LAT = 1).
  logic [31:0] rd_tbl [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  int rd_idx = 0;
  always @(posedge clk) begin
    if (ctrl_enable && (ctrl_operation != 0) && (ctrl_operation[3:0] == 4'd3)) begin
      ctrl_out_data <= rd_tbl[rd_idx];
      rd_idx <= (rd_idx + 1) % 4;
    end
  end

  // Scoreboard: instruction record = {op, cycles held, cycles with enable low}.
  logic [63:0] exp_instr_q[$];
  logic [31:0] exp_wr_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] cur_op = '0;
  int run_cycles = 0, run_stalls = 0, zero_run = 0, done_total = 0, wr_hs = 0;
  bit tight_mode = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      cur_op = '0; run_cycles = 0; run_stalls = 0; zero_run = 0;
    end else begin
      if (ctrl_operation != 0) begin
        if (run_cycles == 0) begin
          if (tight_mode) check("gap_exact", zero_run, 2);
          else check_cond("gap_min", zero_run >= 2, zero_run);
          cur_op = ctrl_operation;
        end else if (ctrl_operation != cur_op) begin
          check("op_stable", ctrl_operation, cur_op);
        end
        run_cycles++;
        if (!ctrl_enable) run_stalls++;
        zero_run = 0;
      end else begin
        zero_run++;
      end
      if (done) begin
        done_total++;
        check_cond("done_expected", exp_instr_q.size() != 0, done_total);
        if (exp_instr_q.size() != 0)
          check("instr", {cur_op, 16'(run_cycles), 16'(run_stalls)}, exp_instr_q.pop_front());
        run_cycles = 0;
        run_stalls = 0;
      end
      if (wdata_valid && wdata_ready) wr_hs++;
      if (ctrl_enable && (ctrl_operation != 0) && (ctrl_operation[3:0] == 4'd2)) begin
        check_cond("wr_expected", exp_wr_q.size() != 0, ctrl_in_data);
        if (exp_wr_q.size() != 0) check("ctrl_in_data", ctrl_in_data, exp_wr_q.pop_front());
      end
      if (result_valid && result_ready) begin
        check_cond("rd_expected", exp_rd_q.size() != 0, result_data);
        if (exp_rd_q.size() != 0) check("result_data", result_data, exp_rd_q.pop_front());
      end
    end
  end

  // Drivers start and end just after a rising edge.
  task automatic push_cmd(input logic [31:0] op, input logic [LEN_W-1:0] len);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len;
    forever begin
      @(negedge clk);
      if (cmd_ready || n >= 200) break;
      n++;
      @(posedge clk); #1;
    end
    check_cond("cmd_accept", n < 200, n);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d);
    int n = 0;
    wdata_valid = 1'b1; wdata = d;
    forever begin
      @(negedge clk);
      if (wdata_ready || n >= 200) break;
      n++;
      @(posedge clk); #1;
    end
    check_cond("wdata_accept", n < 200, n);
    @(posedge clk); #1;
    wdata_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    forever begin
      @(negedge clk);
      if (!busy || n >= budget) break;
      n++;
    end
    check_cond("idle_timeout", n < budget, n);
    @(posedge clk); #1;
  endtask

  task automatic wait_running(input int budget);
    int n = 0;
    forever begin
      @(negedge clk);
      if (ctrl_operation != 0 || n >= budget) break;
      n++;
    end
    check_cond("run_timeout", n < budget, n);
  endtask

  logic [31:0] b2b_ops [5] = '{32'h104, 32'h205, 32'h306, 32'h407, 32'h50F};

  initial begin
    #3;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_enable", ctrl_enable, 0);
    check("rst_operation", ctrl_operation, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_enable", ctrl_enable, 1);
    check("idle_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;

    // Long opcode-1 instruction.
    exp_instr_q.push_back({32'h3241, 16'd600, 16'd0});
    push_cmd(32'h3241, 16'd600);
    wait_idle(800);

    // Load with a two-cycle gap in write data.
    exp_instr_q.push_back({32'h2, 16'd6, 16'd2});
    exp_wr_q.push_back(32'hA); exp_wr_q.push_back(32'hB);
    exp_wr_q.push_back(32'hC); exp_wr_q.push_back(32'hD);
    wr_hs = 0;
    push_cmd(32'h2, 16'd4);
    send_word(32'hA);
    send_word(32'hB);
    repeat (2) @(posedge clk);
    #1;
    send_word(32'hC);
    send_word(32'hD);
    wait_idle(100);
    check("wr_handshakes", wr_hs, 4);

    // Read with a one-cycle backpressure mid-stream.
    exp_instr_q.push_back({32'h3, 16'd5, 16'd1});
    exp_rd_q.push_back(32'h11); exp_rd_q.push_back(32'h22); exp_rd_q.push_back(32'h33);
    push_cmd(32'h3, 16'd3);
    begin
      int n = 0;
      forever begin
        @(negedge clk);
        if ((result_valid && result_ready) || n >= 100) break;
        n++;
      end
      check_cond("rd_first_timeout", n < 100, n);
    end
    @(posedge clk); #1;
    result_ready = 1'b0;
    @(posedge clk); #1;
    result_ready = 1'b1;
    wait_idle(100);
    check("rd_queue_drained", exp_rd_q.size(), 0);

    // Back-to-back commands queued behind a running one.
    exp_instr_q.push_back({32'h1, 16'd20, 16'd0});
    push_cmd(32'h1, 16'd20);
    wait_running(50);
    @(posedge clk); #1;
    tight_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_instr_q.push_back({b2b_ops[i], 16'd3, 16'd0});
      push_cmd(b2b_ops[i], 16'd3);
    end
    @(negedge clk);
    check("cmd_ready_full", cmd_ready, 0);
    @(posedge clk); #1;
    exp_instr_q.push_back({b2b_ops[4], 16'd3, 16'd0});
    push_cmd(b2b_ops[4], 16'd3);
    wait_idle(200);
    tight_mode = 1'b0;

    // Zero-length command is skipped.
    exp_instr_q.push_back({32'h1, 16'd5, 16'd0});
    push_cmd(32'h1, 16'd0);
    push_cmd(32'h1, 16'd5);
    wait_idle(100);

    // Asynchronous reset at beat 3 aborts the instruction and drops the queue.
    push_cmd(32'h1, 16'd10);
    push_cmd(32'h1, 16'd7);
    wait_running(50);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_operation", ctrl_operation, 0);
    check("arst_enable", ctrl_enable, 0);
    check("arst_busy", busy, 0);
    check("arst_cmd_ready", cmd_ready, 0);
    check("arst_done", done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_operation", ctrl_operation, 0);
    check("post_rst_enable", ctrl_enable, 1);

    check("instr_queue_drained", exp_instr_q.size(), 0);
    check("wr_queue_drained", exp_wr_q.size(), 0);
    check("done_total", done_total, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
